// File: rtl/frame_buffer_writer.sv
// Write side of the RGB frame buffer: turns a valid/ready pixel stream into
// row-major linear writes, with frame-completion and resync status pulses.
module frame_buffer_writer #(
  parameter int unsigned H_ACTIVE = 400,
  parameter int unsigned V_ACTIVE = 300,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned PIX_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_red,
  input  logic [PIX_W-1:0]  pix_green,
  input  logic [PIX_W-1:0]  pix_blue,
  input  logic              wr_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_red,
  output logic [PIX_W-1:0]  wr_green,
  output logic [PIX_W-1:0]  wr_blue,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int unsigned X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [X_W-1:0]      x_cnt;
  logic [Y_W-1:0]      y_cnt;
  logic [ADDR_W-1:0]   addr_cnt;
  logic                xfer;
  logic                x_last;
  logic                last_px;

  // Stream handshake: open in IDLE (to flush stale pixels), gated by the buffer in LOAD
  always_comb begin
    pix_ready = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    pix_ready = 1'b1;
        LOAD:    pix_ready = !wr_hold;
        default: pix_ready = 1'b0;
      endcase
    end
  end

  assign xfer    = pix_valid & pix_ready;
  assign x_last  = (x_cnt == X_W'(H_ACTIVE - 1));
  assign last_px = x_last && (y_cnt == Y_W'(V_ACTIVE - 1));

  // Frame FSM, raster counters and registered write port / status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      addr_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_red     <= '0;
      wr_green   <= '0;
      wr_blue    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer && pix_sof) begin
            wr_en    <= 1'b1;
            wr_addr  <= '0;
            wr_red   <= pix_red;
            wr_green <= pix_green;
            wr_blue  <= pix_blue;
            x_cnt    <= X_W'(1);
            y_cnt    <= '0;
            addr_cnt <= ADDR_W'(1);
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            wr_en    <= 1'b1;
            wr_red   <= pix_red;
            wr_green <= pix_green;
            wr_blue  <= pix_blue;
            if (pix_sof) begin
              // Resync: a new frame start always wins, even on the final pixel
              wr_addr  <= '0;
              x_cnt    <= X_W'(1);
              y_cnt    <= '0;
              addr_cnt <= ADDR_W'(1);
              sync_err <= 1'b1;
            end else begin
              wr_addr <= addr_cnt;
              if (last_px) begin
                x_cnt      <= '0;
                y_cnt      <= '0;
                addr_cnt   <= '0;
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= DONE;
              end else if (x_last) begin
                x_cnt    <= '0;
                y_cnt    <= y_cnt + Y_W'(1);
                addr_cnt <= addr_cnt + ADDR_W'(1);
              end else begin
                x_cnt    <= x_cnt + X_W'(1);
                addr_cnt <= addr_cnt + ADDR_W'(1);
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
